enc2freq_scale: RTL

Parametrised rotary-encoder-to-tone-frequency mapper. It sits between the encoder decoder, which supplies single-cycle `cw`/`ccw` pulses, and the tone generator, which consumes `freq` in Hz. It extends the fixed 8-note lookup with the following:
- direction-aware detent counting;
- configurable pulses-per-step;
- multi-octave range;
- wrap or saturate at the range ends;
- major/natural-minor scale select;
- a change strobe for downstream reload.

---
 rtl/enc2freq_scale.sv | 113 +++++++++++
 1 files changed

// File: rtl/enc2freq_scale.sv
// Rotary encoder pulses to scale-note frequency: detent counting, multi-octave
// position with wrap/saturate, major/minor tables and a change strobe.
module enc2freq_scale #(
  parameter int PPS    = 4,
  parameter int N_OCT  = 2,
  parameter int WRAP   = 1,
  parameter int FREQ_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cw,
  input  logic              ccw,
  input  logic              minor,
  output logic [FREQ_W-1:0] freq,
  output logic [2:0]        degree,
  output logic [2:0]        octave,
  output logic              changed
);
  localparam int NPOS = 7 * N_OCT;
  localparam int PW   = (NPOS > 1) ? $clog2(NPOS) : 1;
  localparam logic signed [5:0] CMAX = 6'(PPS - 1);
  localparam logic signed [5:0] CMIN = -CMAX;

  logic [PW-1:0]     pos, pos_n;
  logic signed [5:0] cnt, cnt_n;
  logic [2:0]        deg_n, oct_n;
  logic [15:0]       base_hz;
  logic [FREQ_W-1:0] freq_n;
  logic              up, dn, step_up, step_dn;

  // Opposing pulses in the same cycle cancel out entirely.
  assign up      = cw & ~ccw;
  assign dn      = ccw & ~cw;
  assign step_up = up && (cnt == CMAX);
  assign step_dn = dn && (cnt == CMIN);

  always_comb begin
    cnt_n = cnt;
    pos_n = pos;
    deg_n = degree;
    oct_n = octave;
    if (up) cnt_n = step_up ? 6'sd0 : cnt + 6'sd1;
    if (dn) cnt_n = step_dn ? 6'sd0 : cnt - 6'sd1;
    if (step_up) begin
      if (pos == PW'(NPOS - 1)) begin
        if (WRAP != 0) begin
          pos_n = '0;
          deg_n = 3'd0;
          oct_n = 3'd0;
        end
      end else begin
        pos_n = pos + PW'(1);
        if (degree == 3'd6) begin
          deg_n = 3'd0;
          oct_n = octave + 3'd1;
        end else begin
          deg_n = degree + 3'd1;
        end
      end
    end
    if (step_dn) begin
      if (pos == '0) begin
        if (WRAP != 0) begin
          pos_n = PW'(NPOS - 1);
          deg_n = 3'd6;
          oct_n = 3'(N_OCT - 1);
        end
      end else begin
        pos_n = pos - PW'(1);
        if (degree == 3'd0) begin
          deg_n = 3'd6;
          oct_n = octave - 3'd1;
        end else begin
          deg_n = degree - 3'd1;
        end
      end
    end
  end

  // Degrees 2, 5 and 6 are flattened in natural minor.
  always_comb begin
    base_hz = 16'd262;
    case (degree)
      3'd0:    base_hz = 16'd262;
      3'd1:    base_hz = 16'd294;
      3'd2:    base_hz = minor ? 16'd311 : 16'd330;
      3'd3:    base_hz = 16'd349;
      3'd4:    base_hz = 16'd392;
      3'd5:    base_hz = minor ? 16'd415 : 16'd440;
      3'd6:    base_hz = minor ? 16'd466 : 16'd494;
      default: base_hz = 16'd262;
    endcase
    freq_n = FREQ_W'(base_hz) << octave;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos     <= '0;
      cnt     <= '0;
      degree  <= 3'd0;
      octave  <= 3'd0;
      freq    <= FREQ_W'(262);
      changed <= 1'b0;
    end else begin
      pos     <= pos_n;
      cnt     <= cnt_n;
      degree  <= deg_n;
      octave  <= oct_n;
      freq    <= freq_n;
      changed <= (freq_n != freq);
    end
  end
endmodule
